// File: rtl/gpio8_irq_ctrl.sv
// gpio8_irq_ctrl
// Aggregates the four per-pin GPIO condition classes into 32 sticky raw-status
// flags with write-1-to-clear, applies the interrupt mask, and reports a single
// interrupt request plus the index of the lowest pending masked source.
// Source order is {falling, rising, level-low, level-high}, pin n in bit n of each byte.

module gpio8_irq_ctrl #(
   parameter bit IRQ_REG = 1'b1,
   parameter int NPINS   = 8
) (
   input  logic                          i_clk,
   input  logic                          i_rst_n,
   input  logic [NPINS-1:0]              i_pin_hi,
   input  logic [NPINS-1:0]              i_pin_lo,
   input  logic [NPINS-1:0]              i_pin_pe,
   input  logic [NPINS-1:0]              i_pin_ne,
   input  logic [4*NPINS-1:0]            i_im,
   input  logic [4*NPINS-1:0]            i_icr,
   input  logic                          i_icr_wr,
   output logic [4*NPINS-1:0]            o_ris,
   output logic [4*NPINS-1:0]            o_mis,
   output logic                          o_irq,
   output logic [$clog2(4*NPINS)-1:0]    o_irq_id,
   output logic                          o_irq_valid
);

   localparam int NSRC = 4 * NPINS;
   localparam int IDW  = $clog2(NSRC);

   logic [NSRC-1:0] r_ris;
   logic [NSRC-1:0] w_src;
   logic [NSRC-1:0] w_clr;
   logic [NSRC-1:0] w_mis;
   logic [IDW-1:0]  w_id;
   logic            w_any;

   assign w_src = {i_pin_ne, i_pin_pe, i_pin_lo, i_pin_hi};
   assign w_clr = i_icr_wr ? i_icr : '0;
   assign w_mis = r_ris & i_im;

   // Sticky status: clear first, then OR in new events so a same-cycle set wins.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_ris <= '0;
      end else begin
         r_ris <= (r_ris & ~w_clr) | w_src;
      end
   end

   // Priority encoder: scanning downward leaves the lowest set index in w_id.
   always_comb begin
      w_id  = '0;
      w_any = |w_mis;
      for (int i = NSRC - 1; i >= 0; i--) begin
         if (w_mis[i]) begin
            w_id = IDW'(i);
         end
      end
   end

   generate
      if (IRQ_REG) begin : g_irq_reg
         logic           r_irq;
         logic           r_irq_valid;
         logic [IDW-1:0] r_irq_id;

         // Registered interrupt outputs, one cycle behind the masked status.
         always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
               r_irq       <= 1'b0;
               r_irq_valid <= 1'b0;
               r_irq_id    <= '0;
            end else begin
               r_irq       <= w_any;
               r_irq_valid <= w_any;
               r_irq_id    <= w_id;
            end
         end

         assign o_irq       = r_irq;
         assign o_irq_valid = r_irq_valid;
         assign o_irq_id    = r_irq_id;
      end else begin : g_irq_comb
         assign o_irq       = w_any;
         assign o_irq_valid = w_any;
         assign o_irq_id    = w_id;
      end
   endgenerate

   assign o_ris = r_ris;
   assign o_mis = w_mis;

endmodule

// File: tb/tb_gpio8_irq_ctrl.sv
// Bench for gpio8_irq_ctrl: directed scenarios with literal expectations, then
// randomized traffic (including asynchronous resets) checked every cycle
// against a per-source behavioural model.

module tb_gpio8_irq_ctrl;

   localparam bit IRQ_REG = 1'b1;

   logic        clk;
   logic        rst_n;
   logic [7:0]  pin_hi, pin_lo, pin_pe, pin_ne;
   logic [31:0] im, icr;
   logic        icr_wr;
   logic [31:0] ris, mis;
   logic        irq, irq_valid;
   logic [4:0]  irq_id;

   int checks = 0;
   int errors = 0;
   bit run_cmp = 1'b0;

   gpio8_irq_ctrl #(.IRQ_REG(IRQ_REG), .NPINS(8)) dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_pin_hi    (pin_hi),
      .i_pin_lo    (pin_lo),
      .i_pin_pe    (pin_pe),
      .i_pin_ne    (pin_ne),
      .i_im        (im),
      .i_icr       (icr),
      .i_icr_wr    (icr_wr),
      .o_ris       (ris),
      .o_mis       (mis),
      .o_irq       (irq),
      .o_irq_id    (irq_id),
      .o_irq_valid (irq_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   bit [31:0] m_ris;       // one sticky flag per source
   bit [31:0] m_mis_prev;  // masked status as seen just before the last edge

   function automatic int lowest_set(input bit [31:0] v);
      for (int k = 0; k < 32; k++) if (v[k]) return k;
      return 0;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_ris      = '0;
         m_mis_prev = '0;
      end else begin
         bit [31:0] src;
         src        = {pin_ne, pin_pe, pin_lo, pin_hi};
         m_mis_prev = m_ris & im;
         for (int k = 0; k < 32; k++) begin
            if (src[k])                  m_ris[k] = 1'b1;
            else if (icr_wr && icr[k])   m_ris[k] = 1'b0;
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
      end
   endtask

   // Every-cycle comparison against the model.
   always @(negedge clk) begin
      if (run_cmp) begin
         bit [31:0] src_mis;
         src_mis = IRQ_REG ? m_mis_prev : (m_ris & im);
         chk("ris",       ris,                 m_ris);
         chk("mis",       mis,                 m_ris & im);
         chk("irq",       32'(irq),            32'(src_mis != 0));
         chk("irq_valid", 32'(irq_valid),      32'(src_mis != 0));
         chk("irq_id",    32'(irq_id),         32'(lowest_set(src_mis)));
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_all();
      pin_hi = 0; pin_lo = 0; pin_pe = 0; pin_ne = 0;
      icr = 32'hFFFF_FFFF; icr_wr = 1'b1;
      step();
      icr_wr = 1'b0; icr = 0;
      step();
   endtask

   initial begin
      rst_n = 1'b0; pin_hi = 8'hFF; pin_lo = 0; pin_pe = 0; pin_ne = 0;
      im = 0; icr = 0; icr_wr = 0;
      #2 run_cmp = 1'b1;

      // 1. reset holds flags low despite active level sources
      repeat (3) step();
      chk("rst_ris", ris, 32'h0);
      chk("rst_irq", 32'(irq), 32'h0);
      rst_n = 1'b1;
      step();
      chk("rel_ris", ris, 32'h0000_00FF);
      clear_all();
      chk("clr_ris", ris, 32'h0);

      // 2. rising edge on pin 3, then W1C
      im = 32'h0008_0000; pin_pe = 8'h08;
      step();
      pin_pe = 0;
      chk("pe_ris", ris, 32'h0008_0000);
      chk("pe_irq_early", 32'(irq), 32'h0);
      step();
      chk("pe_irq", 32'(irq), 32'h1);
      chk("pe_id", 32'(irq_id), 32'd19);
      icr = 32'h0008_0000; icr_wr = 1'b1;
      step();
      icr_wr = 0;
      chk("pe_clr_ris", ris, 32'h0);
      step();
      chk("pe_clr_irq", 32'(irq), 32'h0);

      // 3. set beats simultaneous clear
      pin_ne = 8'h80;
      step();
      icr = 32'h8000_0000; icr_wr = 1'b1;
      step();
      pin_ne = 0; icr_wr = 0;
      chk("setwins_ris", ris, 32'h8000_0000);
      icr_wr = 1'b1;
      step();
      icr_wr = 0;
      chk("setwins_clr", ris, 32'h0);

      // 4. masked source latches, appears once unmasked
      im = 0; pin_ne = 8'h01;
      step();
      pin_ne = 0;
      step();
      chk("mask_ris", ris, 32'h0100_0000);
      chk("mask_irq", 32'(irq), 32'h0);
      im = 32'h0100_0000;
      #1 chk("unmask_mis", mis, 32'h0100_0000);
      step();
      chk("unmask_irq", 32'(irq), 32'h1);
      chk("unmask_id", 32'(irq_id), 32'd24);
      clear_all();

      // 5. priority order 5 -> 17 -> 30 -> none
      im = 32'hFFFF_FFFF;
      pin_hi = 8'h20; pin_pe = 8'h02; pin_ne = 8'h40;
      step();
      pin_hi = 0; pin_pe = 0; pin_ne = 0;
      step();
      chk("pri_ris", ris, 32'h4002_0020);
      chk("pri_id5", 32'(irq_id), 32'd5);
      icr = 32'h0000_0020; icr_wr = 1'b1; step(); icr_wr = 0; step();
      chk("pri_id17", 32'(irq_id), 32'd17);
      icr = 32'h0002_0000; icr_wr = 1'b1; step(); icr_wr = 0; step();
      chk("pri_id30", 32'(irq_id), 32'd30);
      icr = 32'h4000_0000; icr_wr = 1'b1; step(); icr_wr = 0; step();
      chk("pri_none_irq", 32'(irq), 32'h0);
      chk("pri_none_vld", 32'(irq_valid), 32'h0);
      chk("pri_none_id", 32'(irq_id), 32'h0);

      // 6. level source cannot be cleared while held
      pin_lo = 8'h04;
      step();
      icr = 32'h0000_0400; icr_wr = 1'b1;
      step();
      icr_wr = 0;
      chk("lvl_hold", ris, 32'h0000_0400);
      pin_lo = 0;
      step();
      icr_wr = 1'b1;
      step();
      icr_wr = 0;
      chk("lvl_clr", ris, 32'h0);

      // randomized traffic with occasional mid-cycle async reset
      for (int n = 0; n < 3000; n++) begin
         pin_hi = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
         pin_lo = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
         pin_pe = 8'($urandom) & 8'($urandom);
         pin_ne = 8'($urandom) & 8'($urandom);
         if ($urandom_range(0, 15) == 0) im = $urandom;
         icr    = $urandom;
         icr_wr = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 199) == 0) begin
            #2 rst_n = 1'b0;
            step();
            step();
            rst_n = 1'b1;
         end else begin
            step();
         end
      end

      run_cmp = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
